// File: rtl/apb_sensor_poller.sv
// apb_sensor_poller
// APB requester that walks the four XADC on-die sensor registers (die temp,
// VCCINT, VCCBRAM, VCCAUX) once per poll interval. It presents the last good
// readings as registered outputs that are updated together at the end of each
// scan. One transfer is outstanding at a time, and the scan is strictly
// sequential.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for an interval request while enable is high
// ST_SETUP   | APB setup phase (psel=1, penable=0), one cycle
// ST_ACCESS  | APB access phase, waiting for pready or the timeout
// ST_RECOVER | one idle bus cycle after an abandoned (timed-out) transfer
// ST_DONE    | scan finished; outputs hold the new set, sensors_update=1

module apb_sensor_poller #(
   parameter int ADDR_WIDTH    = 8,
   parameter int BASE_ADDR     = 0,
   parameter int POLL_INTERVAL = 1000,
   parameter int TIMEOUT       = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [31:0]           pwdata,
   output logic [3:0]            pstrb,
   output logic [2:0]            pprot,
   input  logic [31:0]           prdata,
   input  logic                  pready,
   input  logic                  pslverr,

   input  logic                  enable,
   output logic [15:0]           die_temp,
   output logic [15:0]           volt_core,
   output logic [15:0]           volt_ram,
   output logic [15:0]           volt_aux,
   output logic                  sensors_update,
   output logic                  err_slverr,
   output logic                  err_timeout,
   input  logic                  err_clear
);

   // POLL_INTERVAL >= 16 keeps CNT_W >= 4; TIMEOUT >= 2 keeps the
   // terminal-count compare distinct from the SETUP clear value.
   localparam int CNT_W = $clog2(POLL_INTERVAL);
   localparam int TMO_W = $clog2(TIMEOUT) + 1;

   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(POLL_INTERVAL - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RECOVER,
      ST_DONE
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [CNT_W-1:0]  poll_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [1:0]        idx;
   logic [3:0][15:0]  shadow;
   logic [3:0][15:0]  shadow_next;

   logic              scan_req;
   logic              start_scan;
   logic              resp_ok;
   logic              resp_err;
   logic              tmo_hit;
   logic              last_idx;
   logic              advance;

   // Only the low half-word of each sensor register carries the reading.
   logic              unused_prdata;
   assign unused_prdata = ^prdata[31:16];

   // The counter sits at zero out of reset, so the first IDLE cycle after
   // reset sees a request as well as every later wrap. A request that lands
   // outside IDLE is simply not acted on, so it is dropped rather than queued.
   assign scan_req   = (poll_cnt == '0);
   assign start_scan = (state == ST_IDLE) && scan_req && enable;
   assign resp_ok    = (state == ST_ACCESS) && pready && !pslverr;
   assign resp_err   = (state == ST_ACCESS) && pready && pslverr;
   assign tmo_hit    = (state == ST_ACCESS) && !pready && (tmo_cnt == TMO_LAST);
   assign last_idx   = (idx == 2'd3);
   assign advance    = !last_idx &&
                       (((state == ST_ACCESS) && pready) || (state == ST_RECOVER));

   assign pwrite = 1'b0;
   assign pwdata = '0;
   assign pstrb  = '0;
   assign pprot  = '0;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: responses and timeouts both move on to the next
   // register, so errors never stall the scan.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start_scan) begin
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               state_next = last_idx ? ST_DONE : ST_SETUP;
            end else if (tmo_hit) begin
               state_next = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            state_next = last_idx ? ST_DONE : ST_SETUP;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Bus control and the completion pulse decode directly from the state.
   always_comb begin
      psel           = 1'b0;
      penable        = 1'b0;
      sensors_update = 1'b0;
      case (state)
         ST_SETUP: begin
            psel = 1'b1;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         ST_DONE: begin
            sensors_update = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Free-running interval counter, 0..POLL_INTERVAL-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         poll_cnt <= '0;
      end else if (poll_cnt == CNT_LAST) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + CNT_W'(1);
      end
   end

   // Register index and address. They step together, and paddr stays put
   // for the whole access phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= 2'd0;
         paddr <= ADDR_BASE;
      end else if (start_scan) begin
         idx   <= 2'd0;
         paddr <= ADDR_BASE;
      end else if (advance) begin
         idx   <= idx + 2'd1;
         paddr <= paddr + ADDR_STEP;
      end
   end

   // Access-phase wait counter, cleared in SETUP for each transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == ST_SETUP) begin
         tmo_cnt <= '0;
      end else if ((state == ST_ACCESS) && !pready) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Only a clean response overwrites its shadow slot.
   always_comb begin
      shadow_next = shadow;
      if (resp_ok) begin
         shadow_next[idx] = prdata[15:0];
      end
   end

   // Shadow registers collect the scan in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else begin
         shadow <= shadow_next;
      end
   end

   // Publish all four readings on the edge entering DONE. Loading from
   // shadow_next lets the final capture reach the outputs in the same cycle
   // as the pulse, so consumers see one coherent set while sensors_update=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         die_temp  <= '0;
         volt_core <= '0;
         volt_ram  <= '0;
         volt_aux  <= '0;
      end else if (state_next == ST_DONE) begin
         die_temp  <= shadow_next[0];
         volt_core <= shadow_next[1];
         volt_ram  <= shadow_next[2];
         volt_aux  <= shadow_next[3];
      end
   end

   // Sticky error flags. A new error in the same cycle beats err_clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_slverr  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (resp_err) begin
            err_slverr <= 1'b1;
         end else if (err_clear) begin
            err_slverr <= 1'b0;
         end
         if (tmo_hit) begin
            err_timeout <= 1'b1;
         end else if (err_clear) begin
            err_timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_apb_sensor_poller.sv
// Testbench for apb_sensor_poller: a configurable APB completer that can add
// wait states, return an error or hang per register, plus a scan-level
// reference model that predicts readings, error flags, latency and interval
// phase.

module tb_apb_sensor_poller;

   localparam int AW   = 8;
   localparam int BASE = 0;
   localparam int POLL = 16;
   localparam int TMO  = 64;

   localparam int M_OK   = 0;
   localparam int M_ERR  = 1;
   localparam int M_HANG = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [31:0]   pwdata;
   logic [3:0]    pstrb;
   logic [2:0]    pprot;
   logic [31:0]   prdata;
   logic          pready, pslverr;
   logic          enable;
   logic [15:0]   die_temp, volt_core, volt_ram, volt_aux;
   logic          sensors_update, err_slverr, err_timeout, err_clear;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            k        = 0;
   int            acc_n    = 0;
   logic          prev_err_resp = 1'b0;

   logic [31:0]   cfg_data [4];
   int            cfg_wait [4];
   int            cfg_mode [4];

   logic [15:0]   exp_sens [4];
   logic          exp_slv;
   logic          exp_tmo;

   always #5 clk = ~clk;

   apb_sensor_poller #(
      .ADDR_WIDTH    (AW),
      .BASE_ADDR     (BASE),
      .POLL_INTERVAL (POLL),
      .TIMEOUT       (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .psel           (psel),
      .penable        (penable),
      .pwrite         (pwrite),
      .paddr          (paddr),
      .pwdata         (pwdata),
      .pstrb          (pstrb),
      .pprot          (pprot),
      .prdata         (prdata),
      .pready         (pready),
      .pslverr        (pslverr),
      .enable         (enable),
      .die_temp       (die_temp),
      .volt_core      (volt_core),
      .volt_ram       (volt_ram),
      .volt_aux       (volt_aux),
      .sensors_update (sensors_update),
      .err_slverr     (err_slverr),
      .err_timeout    (err_timeout),
      .err_clear      (err_clear)
   );

   function automatic logic [15:0] sens_out(input int i);
      case (i)
         0:       return die_temp;
         1:       return volt_core;
         2:       return volt_ram;
         default: return volt_aux;
      endcase
   endfunction

   // Advance to the next falling edge and drive the completer's response for
   // the cycle now visible.
   task automatic step();
      int i;
      @(negedge clk);
      k++;
      prev_err_resp = pready && pslverr;
      if (psel && penable) begin
         i = int'(paddr[3:2]);
         acc_n++;
         if (cfg_mode[i] == M_HANG || acc_n <= cfg_wait[i]) begin
            pready  = 1'b0;
            pslverr = 1'($urandom & 1);
            prdata  = $urandom;
         end else begin
            pready  = 1'b1;
            pslverr = (cfg_mode[i] == M_ERR);
            prdata  = cfg_data[i];
         end
      end else begin
         acc_n   = 0;
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = $urandom;
      end
   endtask

   task automatic set_cfg_ok();
      for (int i = 0; i < 4; i++) begin
         cfg_data[i] = $urandom;
         cfg_wait[i] = 0;
         cfg_mode[i] = M_OK;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) exp_sens[i] = 16'h0;
      exp_slv = 1'b0;
      exp_tmo = 1'b0;
   endtask

   // Run one scan with the current completer configuration and check it
   // against the scan-level model.
   task automatic run_scan(input string name, input bit clr_hold, input bit drop_en);
      int            lat_exp, run_exp, start_k, lat, run, maxrun, guard;
      logic [15:0]   old_sens [4];
      logic [15:0]   new_sens [4];
      logic          nslv, ntmo, any_err, any_hang;
      logic          proto_bad, coh_bad, prio_bad, addr_bad;
      logic [AW-1:0] addrs [$];
      logic [AW-1:0] setup_addr;

      lat_exp  = 1;
      run_exp  = 0;
      any_err  = 1'b0;
      any_hang = 1'b0;
      for (int i = 0; i < 4; i++) begin
         old_sens[i] = exp_sens[i];
         new_sens[i] = exp_sens[i];
         if (cfg_mode[i] == M_HANG) begin
            any_hang = 1'b1;
            lat_exp += TMO + 2;
            if (TMO > run_exp) run_exp = TMO;
         end else begin
            lat_exp += cfg_wait[i] + 2;
            if (cfg_wait[i] + 1 > run_exp) run_exp = cfg_wait[i] + 1;
            if (cfg_mode[i] == M_ERR) any_err = 1'b1;
            else new_sens[i] = cfg_data[i][15:0];
         end
      end
      if (clr_hold) begin
         nslv = (cfg_mode[3] == M_ERR);
         ntmo = 1'b0;
      end else begin
         nslv = exp_slv || any_err;
         ntmo = exp_tmo || any_hang;
      end

      guard = 0;
      while (psel !== 1'b1 && guard < 200) begin
         step();
         guard++;
      end
      n_checks++;
      if (psel !== 1'b1) begin
         n_fail++;
         $display("FAIL %s scan_start: psel=%b after %0d cycles, required 1", name, psel, guard);
         return;
      end
      n_checks++;
      if ((k % POLL) != 1) begin
         n_fail++;
         $display("FAIL %s start_phase: scan began at interval phase %0d, required 1", name, k % POLL);
      end

      start_k    = k;
      run        = 0;
      maxrun     = 0;
      proto_bad  = 1'b0;
      coh_bad    = 1'b0;
      prio_bad   = 1'b0;
      setup_addr = '0;
      guard      = 0;
      while (sensors_update !== 1'b1 && guard < 400) begin
         if (psel && !penable) begin
            addrs.push_back(paddr);
            setup_addr = paddr;
         end
         if (psel && penable) begin
            run++;
            if (paddr !== setup_addr) proto_bad = 1'b1;
         end else begin
            if (run > maxrun) maxrun = run;
            run = 0;
         end
         if (pwrite !== 1'b0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0)
            proto_bad = 1'b1;
         for (int i = 0; i < 4; i++)
            if (sens_out(i) !== old_sens[i]) coh_bad = 1'b1;
         if (drop_en && guard == 3) enable = 1'b0;
         step();
         guard++;
         if (clr_hold && err_slverr !== prev_err_resp) prio_bad = 1'b1;
      end
      if (run > maxrun) maxrun = run;

      n_checks++;
      if (sensors_update !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_pulse: sensors_update=%b after %0d cycles, required 1", name, sensors_update, guard);
         return;
      end

      lat = k - start_k + 1;
      n_checks++;
      if (lat != lat_exp) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, lat_exp);
      end

      addr_bad = (addrs.size() != 4);
      if (!addr_bad)
         for (int i = 0; i < 4; i++)
            if (addrs[i] !== AW'(BASE + 4 * i)) addr_bad = 1'b1;
      n_checks++;
      if (addr_bad) begin
         n_fail++;
         $display("FAIL %s addr_seq: %0d setups seen %p, required 0,4,8,c", name, addrs.size(), addrs);
      end

      n_checks++;
      if (maxrun != run_exp) begin
         n_fail++;
         $display("FAIL %s access_run: longest access %0d cycles, required %0d", name, maxrun, run_exp);
      end

      n_checks++;
      if (proto_bad) begin
         n_fail++;
         $display("FAIL %s protocol: paddr moved in access or write fields nonzero, got 1 required 0", name);
      end

      n_checks++;
      if (coh_bad) begin
         n_fail++;
         $display("FAIL %s coherency: outputs changed before done, got 1 required 0", name);
      end

      if (clr_hold) begin
         n_checks++;
         if (prio_bad) begin
            n_fail++;
            $display("FAIL %s err_priority: err_slverr did not track set-over-clear, got 1 required 0", name);
         end
      end

      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (sens_out(i) !== new_sens[i]) begin
            n_fail++;
            $display("FAIL %s sensor%0d: got %h, required %h", name, i, sens_out(i), new_sens[i]);
         end
      end

      n_checks++;
      if (err_slverr !== nslv) begin
         n_fail++;
         $display("FAIL %s err_slverr: got %b, required %b", name, err_slverr, nslv);
      end
      n_checks++;
      if (err_timeout !== ntmo) begin
         n_fail++;
         $display("FAIL %s err_timeout: got %b, required %b", name, err_timeout, ntmo);
      end

      for (int i = 0; i < 4; i++) exp_sens[i] = new_sens[i];
      exp_slv = nslv;
      exp_tmo = ntmo;

      step();
      n_checks++;
      if (sensors_update !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pulse_width: sensors_update=%b one cycle after done, required 0", name, sensors_update);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      enable    = 1'b1;
      err_clear = 1'b0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = 32'h0;
      set_cfg_ok();
      repeat (3) step();
      n_checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin
         n_fail++;
         $display("FAIL reset bus_ctrl: psel/penable/pwrite=%b%b%b, required 000", psel, penable, pwrite);
      end
      n_checks++;
      if (paddr !== AW'(BASE)) begin
         n_fail++;
         $display("FAIL reset paddr: got %h, required %h", paddr, AW'(BASE));
      end
      n_checks++;
      if ({die_temp, volt_core, volt_ram, volt_aux} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset sensors: got %h %h %h %h, required all 0", die_temp, volt_core, volt_ram, volt_aux);
      end
      n_checks++;
      if ({sensors_update, err_slverr, err_timeout} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset flags: update/slverr/timeout=%b%b%b, required 000", sensors_update, err_slverr, err_timeout);
      end
      model_reset();
      rst = 1'b0;
      k   = 0;
   endtask

   task automatic test_fixed_values();
      set_cfg_ok();
      cfg_data[0] = 32'h0000_1234;
      cfg_data[1] = 32'h0000_5555;
      cfg_data[2] = 32'h0000_2AAA;
      cfg_data[3] = 32'h0000_7FFF;
      run_scan("fixed_values", 1'b0, 1'b0);
   endtask

   task automatic test_wait_states();
      set_cfg_ok();
      cfg_data[1] = 32'hA5A5_5555;
      cfg_wait[2] = 3;
      run_scan("wait_states", 1'b0, 1'b0);
   endtask

   task automatic test_slverr();
      set_cfg_ok();
      cfg_data[1] = 32'h0000_DEAD;
      cfg_mode[1] = M_ERR;
      run_scan("slverr", 1'b0, 1'b0);
   endtask

   task automatic test_err_clear();
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      exp_slv   = 1'b0;
      exp_tmo   = 1'b0;
      n_checks++;
      if (err_slverr !== 1'b0 || err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: slverr/timeout=%b%b, required 00", err_slverr, err_timeout);
      end
   endtask

   task automatic test_timeout();
      set_cfg_ok();
      cfg_mode[3] = M_HANG;
      run_scan("timeout", 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 3; n++) begin
         set_cfg_ok();
         run_scan("back_to_back", 1'b0, 1'b0);
      end
   endtask

   task automatic test_err_priority();
      set_cfg_ok();
      cfg_mode[1] = M_ERR;
      err_clear   = 1'b1;
      run_scan("err_priority", 1'b1, 1'b0);
      err_clear   = 1'b0;
   endtask

   task automatic test_random();
      int r;
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 4; i++) begin
            cfg_data[i] = $urandom;
            cfg_wait[i] = $urandom_range(0, 4);
            r = $urandom_range(0, 15);
            cfg_mode[i] = (r < 2) ? M_ERR : ((r == 2) ? M_HANG : M_OK);
         end
         run_scan("random", 1'b0, 1'b0);
         if (n % 5 == 4) test_err_clear();
      end
   endtask

   task automatic test_enable_toggle();
      logic psel_seen;
      set_cfg_ok();
      run_scan("enable_drop", 1'b0, 1'b1);
      psel_seen = 1'b0;
      repeat (3 * POLL) begin
         step();
         if (psel !== 1'b0) psel_seen = 1'b1;
      end
      n_checks++;
      if (psel_seen) begin
         n_fail++;
         $display("FAIL enable_off: psel activity with enable=0, got 1 required 0");
      end
      repeat ($urandom_range(0, 15)) step();
      set_cfg_ok();
      enable = 1'b1;
      run_scan("enable_restart", 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_access();
      int guard;
      set_cfg_ok();
      cfg_wait[1] = 6;
      guard = 0;
      while (!(psel === 1'b1 && penable === 1'b1 && paddr === AW'(BASE + 4)) && guard < 200) begin
         step();
         guard++;
      end
      n_checks++;
      if (!(psel === 1'b1 && penable === 1'b1 && paddr === AW'(BASE + 4))) begin
         n_fail++;
         $display("FAIL reset_mid find_access: no access at addr 4 within %0d cycles", guard);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid bus_ctrl: psel/penable=%b%b, required 00", psel, penable);
      end
      n_checks++;
      if ({die_temp, volt_core, volt_ram, volt_aux} !== 64'h0 || paddr !== AW'(BASE)) begin
         n_fail++;
         $display("FAIL reset_mid outputs: sensors %h %h %h %h paddr %h, required all 0", die_temp, volt_core, volt_ram, volt_aux, paddr);
      end
      n_checks++;
      if ({sensors_update, err_slverr, err_timeout} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid flags: update/slverr/timeout=%b%b%b, required 000", sensors_update, err_slverr, err_timeout);
      end
      repeat (2) step();
      model_reset();
      set_cfg_ok();
      rst = 1'b0;
      k   = 0;
      run_scan("post_reset", 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fixed_values();
      test_wait_states();
      test_slverr();
      test_err_clear();
      test_timeout();
      test_err_clear();
      test_back_to_back();
      test_err_priority();
      test_random();
      test_enable_toggle();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
